lcd_init_sequencer: RTL and testbench

Walks the LCD init-data ROM from address 0, decodes each 16-bit entry as a command byte, a data byte, a delay or an end marker, and replays the sequence to the LCD byte writer over a valid/ready handshake. Sits between the init-data ROM and the LCD printer's bus writer. Runs once per `start` pulse and reports `busy` and `done` to the printer top.

---
 rtl/lcd_init_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_sequencer.sv
// Replays the LCD init-data ROM (command/data/delay/end entries) to the LCD byte writer.
// Define LCD_INIT_HW_RESET_EN to add the lcd_rst_n pin and the hardware-reset phase.
module lcd_init_sequencer #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 16,
    parameter int DELAY_UNIT   = 50000,
    parameter int HWRST_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  wr_dc,
    output logic [7:0]            wr_data
`ifdef LCD_INIT_HW_RESET_EN
    ,
    output logic                  lcd_rst_n
`endif
);

    if (DATA_WIDTH != 16 || DELAY_UNIT < 1 || HWRST_CYCLES < 1) begin : g_param_check
        $error("lcd_init_sequencer: DATA_WIDTH must be 16, DELAY_UNIT and HWRST_CYCLES >= 1");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [31:0]           DU_LAST   = 32'(DELAY_UNIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_DELAY = 3'd3,
        S_DONE  = 3'd4
`ifdef LCD_INIT_HW_RESET_EN
        ,
        S_HWRST = 3'd5
`endif
    } state_t;

    state_t      state;
    logic [31:0] pre_cnt;
    logic [13:0] unit_cnt;
    logic        at_last;

`ifdef LCD_INIT_HW_RESET_EN
    localparam logic [31:0] HW_LAST = 32'(HWRST_CYCLES - 1);
    logic [31:0] hw_cnt;
    logic        hw_phase;
`endif

    assign at_last = (rom_addr == LAST_ADDR);

    // Finishing an entry at the last address ends the sequence rather than wrapping to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
            wr_valid <= 1'b0;
            wr_dc    <= 1'b0;
            wr_data  <= '0;
            pre_cnt  <= '0;
            unit_cnt <= '0;
`ifdef LCD_INIT_HW_RESET_EN
            lcd_rst_n <= 1'b1;
            hw_cnt    <= '0;
            hw_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        rom_addr <= '0;
`ifdef LCD_INIT_HW_RESET_EN
                        lcd_rst_n <= 1'b0;
                        hw_cnt    <= '0;
                        hw_phase  <= 1'b0;
                        state     <= S_HWRST;
`else
                        state    <= S_FETCH;
`endif
                    end
                end
`ifdef LCD_INIT_HW_RESET_EN
                S_HWRST: begin
                    if (hw_cnt == HW_LAST) begin
                        hw_cnt <= '0;
                        if (!hw_phase) begin
                            hw_phase  <= 1'b1;
                            lcd_rst_n <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        hw_cnt <= hw_cnt + 32'd1;
                    end
                end
`endif
                S_FETCH: begin
                    case (rom_data[15:14])
                        2'b00, 2'b01: begin
                            wr_valid <= 1'b1;
                            wr_dc    <= rom_data[14];
                            wr_data  <= rom_data[7:0];
                            state    <= S_SEND;
                        end
                        2'b10: begin
                            if (rom_data[13:0] != 14'd0) begin
                                unit_cnt <= rom_data[13:0];
                                pre_cnt  <= '0;
                                state    <= S_DELAY;
                            end else if (at_last) begin
                                state <= S_DONE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                        default: state <= S_DONE;
                    endcase
                end
                S_SEND: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (at_last) begin
                            state <= S_DONE;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (pre_cnt == DU_LAST) begin
                        pre_cnt <= '0;
                        if (unit_cnt == 14'd1) begin
                            if (at_last) begin
                                state <= S_DONE;
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= S_FETCH;
                            end
                        end else begin
                            unit_cnt <= unit_cnt - 14'd1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    wr_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer: ADDR_WIDTH=3, DELAY_UNIT=4, HWRST_CYCLES=5.
module tb_lcd_init_sequencer;

    localparam int AW = 3;
`ifdef LCD_INIT_HW_RESET_EN
    localparam int HW = 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          wr_valid;
    logic          wr_ready = 1'b1;
    logic          wr_dc;
    logic [7:0]    wr_data;
`ifdef LCD_INIT_HW_RESET_EN
    logic          lcd_rst_n;
`endif

    logic [15:0] rom [8];
    assign rom_data = rom[rom_addr];

    int errors = 0;
    int checks = 0;

    lcd_init_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (16),
        .DELAY_UNIT  (4),
        .HWRST_CYCLES(5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_dc    (wr_dc),
        .wr_data  (wr_data)
`ifdef LCD_INIT_HW_RESET_EN
        ,
        .lcd_rst_n(lcd_rst_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int i = 0; i < 8; i++) rom[i] = 16'hC000;
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
    endtask

    // Leaves the bench sampling the cycle in which address 0 is fetched.
    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef LCD_INIT_HW_RESET_EN
        repeat (2 * HW) tick();
`endif
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int bytes;
        int wraps;
        logic left_zero;

        set_rom(16'h0011, 16'h4055, 16'hC000);
        repeat (2) tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {29'd0, rom_addr}, 32'd0);
        check("rst_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_dc", {31'd0, wr_dc}, 32'd0);
        check("rst_data", {24'd0, wr_data}, 32'd0);
`ifdef LCD_INIT_HW_RESET_EN
        check("rst_lcd_rst_n", {31'd0, lcd_rst_n}, 32'd1);
`endif

        // Basic two-byte sequence, writer always ready.
        do_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_valid", {31'd0, wr_valid}, 32'd0);
        tick();
        check("t1_b0", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'h11});
        tick();
        check("t1_fetch1", {28'd0, wr_valid, rom_addr}, {28'd0, 1'b0, 3'd1});
        tick();
        check("t1_b1", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b1, 8'h55});
        tick();
        check("t1_fetch2", {28'd0, wr_valid, rom_addr}, {28'd0, 1'b0, 3'd2});
        tick();
        check("t1_done_state", {30'd0, busy, done}, {30'd0, 1'b1, 1'b0});
        tick();
        check("t1_idle", {30'd0, busy, done}, {30'd0, 1'b0, 1'b1});
        repeat (3) tick();
        check("t1_done_sticky", {31'd0, done}, 32'd1);

        // Back-pressure: hold the first byte for 7 not-ready cycles.
        wr_ready = 1'b0;
        do_start();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            check("t2_hold", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'h11});
            tick();
        end
        wr_ready = 1'b1;
        check("t2_hs", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'h11});
        tick();
        check("t2_after_hs", {28'd0, wr_valid, rom_addr}, {28'd0, 1'b0, 3'd1});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_no_restart", {25'd0, wr_valid, wr_dc, rom_addr, wr_data[3:0]},
              {25'd0, 1'b1, 1'b1, 3'd1, 4'h5});
        wait_idle(20);
        check("t2_done", {31'd0, done}, 32'd1);

        // Delay of 3 units of 4 cycles before the first byte.
        set_rom(16'h8003, 16'h0029, 16'hC000);
        do_start();
        n = 0;
        while (!wr_valid && n < 100) begin
            tick();
            n++;
        end
        check("t3_delay_lat", n, 32'd14);
        check("t3_byte", {23'd0, wr_dc, wr_data}, {23'd0, 1'b0, 8'h29});
        wait_idle(20);

        set_rom(16'h8000, 16'h0029, 16'hC000);
        do_start();
        tick();
        check("t3_zero_addr", {28'd0, wr_valid, rom_addr}, {28'd0, 1'b0, 3'd1});
        tick();
        check("t3_zero_byte", {23'd0, wr_valid, wr_data}, {23'd0, 1'b1, 8'h29});
        wait_idle(20);

        // No end marker: 8 command bytes, then done without wrapping.
        for (int i = 0; i < 8; i++) rom[i] = 16'h3FA0 + 16'(i) - 16'h3F00;
        do_start();
        n = 0;
        bytes = 0;
        wraps = 0;
        left_zero = 1'b0;
        while (busy && n < 60) begin
            if (wr_valid) begin
                check("t4_byte", {23'd0, wr_dc, wr_data}, {23'd0, 1'b0, 8'hA0 + 8'(bytes)});
                bytes++;
            end
            if (rom_addr != 3'd0) left_zero = 1'b1;
            else if (left_zero) wraps++;
            tick();
            n++;
        end
        check("t4_busy_len", n, 32'd17);
        check("t4_bytes", bytes, 32'd8);
        check("t4_wraps", wraps, 32'd0);
        check("t4_end", {28'd0, done, rom_addr}, {28'd0, 1'b1, 3'd7});

        // Reset with a byte in flight, then restart from address 0.
        set_rom(16'h0011, 16'h4055, 16'hC000);
        wr_ready = 1'b0;
        do_start();
        tick();
        check("t5_inflight", {31'd0, wr_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst", {26'd0, busy, done, wr_valid, wr_dc, rom_addr == 3'd0, wr_data == 8'h00},
              {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        wr_ready = 1'b1;
        do_start();
        tick();
        check("t5_restart", {20'd0, wr_valid, rom_addr, wr_data}, {20'd0, 1'b1, 3'd0, 8'h11});
        wait_idle(20);
        check("t5_done", {31'd0, done}, 32'd1);

`ifdef LCD_INIT_HW_RESET_EN
        // Hardware reset pulse timing and reset during the pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!lcd_rst_n && n < 50) begin
            n++;
            tick();
        end
        check("hw_low", n, 32'd5);
        check("hw_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!wr_valid && n < 50) begin
            tick();
            n++;
        end
        check("hw_high_to_valid", n, 32'd6);
        wait_idle(20);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("hw_rst_pin", {30'd0, lcd_rst_n, busy}, {30'd0, 1'b1, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
